// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared widths, FSM states and the address-derived test pattern
package mem_burst_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    typedef enum logic [2:0] {INIT_WAIT, IDLE, WR, RD, NEXT} state_e;

    function automatic logic [DATA_W-1:0] pat64(input logic [ADDR_W-1:0] a);
        return {8'h00, ~a, 8'h00, a};
    endfunction
endpackage

// File: rtl/mem_burst_checker.sv
// mem_burst_checker: read-back compare with sticky error, saturating error count and per-burst bad flag
module mem_burst_checker
    import mem_burst_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] expected_i,
    input  logic              clr_i,
    output logic              error_o,
    output logic [15:0]       error_cnt_o,
    output logic              burst_bad_o
);
    logic        error_q, burst_bad_q, miss;
    logic [15:0] error_cnt_q, error_cnt_d;

    assign miss        = valid_i && (data_i != expected_i);
    assign error_cnt_d = error_cnt_q + {15'd0, error_cnt_q != 16'hFFFF};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q     <= 1'b0;
            error_cnt_q <= '0;
            burst_bad_q <= 1'b0;
        end else begin
            if (miss) begin
                error_q     <= 1'b1;
                error_cnt_q <= error_cnt_d;
            end
            burst_bad_q <= clr_i ? 1'b0 : (burst_bad_q | miss);
        end
    end

    assign error_o     = error_q;
    assign error_cnt_o = error_cnt_q;
    assign burst_bad_o = burst_bad_q;
endmodule

// File: rtl/mem_burst_tester.sv
// mem_burst_tester: write/read-verify sweep initiator for the DDR2 burst adapter.
// Optional MEM_BURST_TESTER_ERR_INJECT_EN adds err_inject to flip bit 0 of one write word.
module mem_burst_tester
    import mem_burst_pkg::*;
#(
    parameter int                BURST_LEN = 128,
    parameter logic [ADDR_W-1:0] ADDR_MAX  = 24'hFF_FFFF,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 24'h00_0000
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              local_initial_done,
    input  logic              test_en,
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              rd_burst_req,
    output logic              wr_burst_req,
    output logic [LEN_W-1:0]  rd_burst_len,
    output logic [LEN_W-1:0]  wr_burst_len,
    output logic [ADDR_W-1:0] rd_burst_addr,
    output logic [ADDR_W-1:0] wr_burst_addr,
    input  logic              wr_burst_data_req,
    output logic [DATA_W-1:0] wr_burst_data,
    input  logic              rd_burst_data_valid,
    input  logic [DATA_W-1:0] rd_burst_data,
    input  logic              burst_finish,
    output logic              error,
    output logic [15:0]       error_cnt,
    output logic [15:0]       pass_cnt,
    output logic              busy
);
    localparam logic [LEN_W-1:0]  LEN      = LEN_W'(BURST_LEN);
    localparam logic [ADDR_W:0]   STEP_LIM = {1'b0, ADDR_MAX} - (ADDR_W+1)'(BURST_LEN) + 1'b1;

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  wr_idx_q, rd_idx_q;
    logic              wr_req_q, rd_req_q, busy_q;
    logic [DATA_W-1:0] wr_data_q, wr_word_d;
    logic [15:0]       pass_cnt_q;
    logic [ADDR_W:0]   addr_nxt;
    logic              wr_beat, rd_beat, burst_bad;

    // Step computed in 25 bits so ranges ending near 24'hFFFFFF cannot overflow
    assign addr_nxt = {1'b0, cur_addr_q} + (ADDR_W+1)'(BURST_LEN);
    assign wr_beat  = local_initial_done && state_q == WR && wr_burst_data_req && wr_idx_q < LEN;
    assign rd_beat  = local_initial_done && state_q == RD && rd_burst_data_valid && rd_idx_q < LEN;

`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
    logic inj_q;
    assign wr_word_d = pat64(cur_addr_q + ADDR_W'(wr_idx_q)) ^ {{(DATA_W-1){1'b0}}, inj_q};
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) inj_q <= 1'b0;
        else        inj_q <= (inj_q && wr_beat) ? 1'b0 : (inj_q || err_inject);
    end
`else
    assign wr_word_d = pat64(cur_addr_q + ADDR_W'(wr_idx_q));
`endif

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_WAIT;
            cur_addr_q <= ADDR_BASE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_data_q  <= '0;
            pass_cnt_q <= '0;
        end else if (!local_initial_done) begin
            // Adapter aborts silently: drop the partial burst, keep address and counters
            state_q  <= INIT_WAIT;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b1;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            case (state_q)
                INIT_WAIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                IDLE: if (test_en) begin
                    state_q   <= WR;
                    wr_req_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    wr_data_q <= pat64(cur_addr_q);
                end
                WR: begin
                    if (wr_beat) begin
                        wr_data_q <= wr_word_d;
                        wr_idx_q  <= wr_idx_q + 1'b1;
                    end
                    if (burst_finish) begin
                        wr_req_q <= 1'b0;
                        rd_req_q <= 1'b1;
                        state_q  <= RD;
                    end
                end
                RD: begin
                    if (rd_beat) rd_idx_q <= rd_idx_q + 1'b1;
                    if (burst_finish) begin
                        rd_req_q <= 1'b0;
                        state_q  <= NEXT;
                    end
                end
                NEXT: begin
                    if (!burst_bad) pass_cnt_q <= pass_cnt_q + 16'd1;
                    wr_idx_q   <= '0;
                    rd_idx_q   <= '0;
                    cur_addr_q <= addr_nxt > STEP_LIM ? ADDR_BASE : addr_nxt[ADDR_W-1:0];
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                end
                default: state_q <= INIT_WAIT;
            endcase
        end
    end

    mem_burst_checker u_chk (
        .clk_i       (mem_clk),
        .rst_ni      (rst_n),
        .valid_i     (rd_beat),
        .data_i      (rd_burst_data),
        .expected_i  (pat64(cur_addr_q + ADDR_W'(rd_idx_q))),
        .clr_i       (state_q == NEXT || !local_initial_done),
        .error_o     (error),
        .error_cnt_o (error_cnt),
        .burst_bad_o (burst_bad)
    );

    assign rd_burst_req  = rd_req_q;
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_len  = LEN;
    assign wr_burst_len  = LEN;
    assign rd_burst_addr = cur_addr_q;
    assign wr_burst_addr = cur_addr_q;
    assign wr_burst_data = wr_data_q;
    assign pass_cnt      = pass_cnt_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_burst_tester.sv
// tb_mem_burst_tester: adapter + memory model driving mem_burst_tester, plus a saturation instance
module tb_mem_burst_tester;
    localparam int          BL   = 128;
    localparam int          SBL  = 512;
    localparam logic [23:0] AMAX = 24'h0003FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, done, en, wr_dreq, rd_valid, fin, inj;
    logic [63:0] rd_data, wr_data;
    logic        rd_req, wr_req, error, busy;
    logic [9:0]  rd_len, wr_len;
    logic [23:0] rd_addr, wr_addr;
    logic [15:0] error_cnt, pass_cnt;

    logic        s_rst_n, s_done, s_en, s_wr_dreq, s_rd_valid, s_fin, s_inj;
    logic [63:0] s_rd_data, s_wr_data;
    logic        s_rd_req, s_wr_req, s_error, s_busy;
    logic [9:0]  s_rd_len, s_wr_len;
    logic [23:0] s_rd_addr, s_wr_addr;
    logic [15:0] s_error_cnt, s_pass_cnt;

    mem_burst_tester #(.BURST_LEN(BL), .ADDR_MAX(AMAX), .ADDR_BASE(24'h000000)) dut (
        .mem_clk(clk), .rst_n(rst_n), .local_initial_done(done), .test_en(en),
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
        .err_inject(inj),
`endif
        .rd_burst_req(rd_req), .wr_burst_req(wr_req), .rd_burst_len(rd_len), .wr_burst_len(wr_len),
        .rd_burst_addr(rd_addr), .wr_burst_addr(wr_addr), .wr_burst_data_req(wr_dreq),
        .wr_burst_data(wr_data), .rd_burst_data_valid(rd_valid), .rd_burst_data(rd_data),
        .burst_finish(fin), .error(error), .error_cnt(error_cnt), .pass_cnt(pass_cnt), .busy(busy)
    );

    mem_burst_tester #(.BURST_LEN(SBL), .ADDR_MAX(AMAX), .ADDR_BASE(24'h000000)) dut_sat (
        .mem_clk(clk), .rst_n(s_rst_n), .local_initial_done(s_done), .test_en(s_en),
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
        .err_inject(s_inj),
`endif
        .rd_burst_req(s_rd_req), .wr_burst_req(s_wr_req), .rd_burst_len(s_rd_len), .wr_burst_len(s_wr_len),
        .rd_burst_addr(s_rd_addr), .wr_burst_addr(s_wr_addr), .wr_burst_data_req(s_wr_dreq),
        .wr_burst_data(s_wr_data), .rd_burst_data_valid(s_rd_valid), .rd_burst_data(s_rd_data),
        .burst_finish(s_fin), .error(s_error), .error_cnt(s_error_cnt), .pass_cnt(s_pass_cnt), .busy(s_busy)
    );

    int          total = 0, bad = 0;
    int          m_addr, m_pass, m_err;
    logic [63:0] mem [0:1023];
    bit          sat_done = 1'b0;

    typedef struct {
        int          corrupt;
        logic [23:0] addr;
        logic [23:0] nxt;
        logic [15:0] pass;
        logic [15:0] ecnt;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [63:0] pat(input logic [23:0] a);
        return {8'h00, ~a, 8'h00, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        while (!wr_req && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_pair(input int corrupt, input bit rnd, input bit injw, input bit drop_en,
                            output int lat, output logic [63:0] w0, output logic [23:0] a0);
        int n, wbad, bw, k;
        logic [63:0] d, e;
        bit sep;
        w0 = '0;
        a0 = '0;
        wait_wr(n);
        lat = n;
        check("wr_req_rise", 64'(wr_req), 64'd1);
        if (!wr_req) return;
        a0 = wr_addr;
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_preload", wr_data, pat(24'(m_addr)));
        if (drop_en) en = 1'b0;
        wbad = 0;
        for (int i = 0; i < BL; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            wr_dreq = 1'b1;
            tick();
            wr_dreq = 1'b0;
            e = pat(24'(m_addr + i)) ^ 64'(injw && i == 0);
            if (i == 0) w0 = wr_data;
            if (wr_data !== e) wbad++;
            mem[(m_addr + i) % 1024] = wr_data;
        end
        if (rnd && $urandom_range(0, 1) == 1) begin
            wr_dreq = 1'b1;
            tick();
            tick();
            wr_dreq = 1'b0;
            check("wr_extra_hold", wr_data, mem[(m_addr + BL - 1) % 1024]);
        end
        check("wr_data_seq", 64'(wbad), 64'd0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        check("wr_req_drop", 64'(wr_req), 64'd0);
        check("rd_req_rise", 64'(rd_req), 64'd1);
        check("rd_addr", 64'(rd_addr), 64'(m_addr));
        sep = rnd && $urandom_range(0, 1) == 1;
        bw = 0;
        for (int i = 0; i < BL; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            d = mem[(m_addr + i) % 1024];
            if (i == corrupt) d[63] = ~d[63];
            if (rnd && $urandom_range(0, 31) == 0) begin
                k = $urandom_range(0, 63);
                d[k] = ~d[k];
            end
            if (d !== pat(24'(m_addr + i))) bw++;
            rd_data = d;
            rd_valid = 1'b1;
            fin = (i == BL - 1) && !sep;
            tick();
            rd_valid = 1'b0;
            fin = 1'b0;
        end
        if (sep) begin
            rd_data = '1;
            rd_valid = 1'b1;
            tick();
            rd_valid = 1'b0;
            fin = 1'b1;
            tick();
            fin = 1'b0;
        end
        m_err = (m_err + bw > 65535) ? 65535 : m_err + bw;
        if (bw == 0) m_pass++;
        // next burst must fit entirely below ADDR_MAX, otherwise restart at base
        m_addr = (m_addr + 2 * BL - 1 > int'(AMAX)) ? 0 : m_addr + BL;
        tick();
        check("pass_cnt", 64'(pass_cnt), 64'(16'(m_pass)));
        check("error_cnt", 64'(error_cnt), 64'(m_err));
        check("error_flag", 64'(error), 64'(m_err != 0));
        check("rd_req_drop", 64'(rd_req), 64'd0);
        check("next_addr", 64'(wr_addr), 64'(m_addr));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int lat, n, e0;
        logic [63:0] w0;
        logic [23:0] a0;
        vecs[0] = '{-1, 24'h000, 24'h080, 16'd1, 16'd0};
        vecs[1] = '{-1, 24'h080, 24'h100, 16'd2, 16'd0};
        vecs[2] = '{-1, 24'h100, 24'h180, 16'd3, 16'd0};
        vecs[3] = '{-1, 24'h180, 24'h200, 16'd4, 16'd0};
        vecs[4] = '{-1, 24'h200, 24'h280, 16'd5, 16'd0};
        vecs[5] = '{-1, 24'h280, 24'h300, 16'd6, 16'd0};
        vecs[6] = '{-1, 24'h300, 24'h380, 16'd7, 16'd0};
        vecs[7] = '{-1, 24'h380, 24'h000, 16'd8, 16'd0};
        vecs[8] = '{ 5, 24'h000, 24'h080, 16'd8, 16'd1};
        vecs[9] = '{-1, 24'h080, 24'h100, 16'd9, 16'd1};
        m_addr = 0; m_pass = 0; m_err = 0;
        rst_n = 1'b0; done = 1'b0; en = 1'b0; wr_dreq = 1'b0; rd_valid = 1'b0;
        fin = 1'b0; inj = 1'b0; rd_data = '0;
        tick();
        tick();
        check("rst_flags", 64'({rd_req, wr_req, error, busy}), 64'd0);
        check("rst_error_cnt", 64'(error_cnt), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_addr", 64'({wr_addr, rd_addr}), 64'd0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) tick();
        check("init_wait_busy", 64'(busy), 64'd1);
        check("init_wait_noreq", 64'(wr_req), 64'd0);
        check("burst_len", 64'({rd_len, wr_len}), 64'({10'd128, 10'd128}));
        en = 1'b0;
        done = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        check("fin_in_idle", 64'({busy, wr_req, rd_req}), 64'd0);
        en = 1'b1;
        for (int v = 0; v < 10; v++) begin
            run_pair(vecs[v].corrupt, 1'b0, 1'b0, 1'b0, lat, w0, a0);
            check("vec_lat", 64'(lat), 64'd1);
            check("vec_addr", 64'(a0), 64'(vecs[v].addr));
            check("vec_nxt", 64'(wr_addr), 64'(vecs[v].nxt));
            check("vec_pass", 64'(pass_cnt), 64'(vecs[v].pass));
            check("vec_ecnt", 64'(error_cnt), 64'(vecs[v].ecnt));
            if (v == 0) check("word0", w0, 64'h00FFFFFF_00000000);
        end
        rst_n = 1'b0;
        tick();
        check("rerst_cnts", 64'({error_cnt, pass_cnt, 15'd0, error}), 64'd0);
        m_addr = 0; m_pass = 0; m_err = 0;
        rst_n = 1'b1;
        run_pair(-1, 1'b0, 1'b0, 1'b0, lat, w0, a0);
        run_pair(-1, 1'b0, 1'b0, 1'b0, lat, w0, a0);
        wait_wr(n);
        check("abort_addr", 64'(wr_addr), 64'h100);
        for (int i = 0; i < 50; i++) begin
            wr_dreq = 1'b1;
            tick();
        end
        wr_dreq = 1'b0;
        done = 1'b0;
        tick();
        check("abort_reqs", 64'({wr_req, rd_req}), 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        repeat (3) tick();
        check("abort_park", 64'(wr_req), 64'd0);
        check("abort_pass", 64'(pass_cnt), 64'd2);
        check("abort_keep_addr", 64'(wr_addr), 64'h100);
        done = 1'b1;
        run_pair(-1, 1'b0, 1'b0, 1'b0, lat, w0, a0);
        check("restart_addr", 64'(a0), 64'h100);
        check("restart_pass", 64'(pass_cnt), 64'd3);
        for (int r = 0; r < 12; r++) run_pair(-1, 1'b1, 1'b0, 1'b0, lat, w0, a0);
        run_pair(-1, 1'b1, 1'b0, 1'b1, lat, w0, a0);
        repeat (8) tick();
        check("en_drop_park", 64'({wr_req, busy}), 64'd0);
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        e0 = m_err;
        en = 1'b1;
        run_pair(-1, 1'b0, 1'b1, 1'b1, lat, w0, a0);
        check("inj_once", 64'(error_cnt), 64'(e0 + 1));
`endif
        n = 0;
        while (!sat_done && n < 100000) begin
            tick();
            n++;
        end
        check("sat_done", 64'(sat_done), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Saturation: reads of all-ones never match the pattern, so every valid beat is a mismatch
    initial begin
        int n, exp;
        s_rst_n = 1'b0; s_done = 1'b0; s_en = 1'b0; s_wr_dreq = 1'b0; s_rd_valid = 1'b0;
        s_fin = 1'b0; s_inj = 1'b0; s_rd_data = '1;
        repeat (3) tick();
        s_rst_n = 1'b1;
        s_done = 1'b1;
        s_en = 1'b1;
        for (int b = 0; b < 130; b++) begin
            n = 0;
            while (!s_wr_req && n < 40) begin
                tick();
                n++;
            end
            if (!s_wr_req) begin
                check("sat_wr_req", 64'(s_wr_req), 64'd1);
                break;
            end
            s_fin = 1'b1;
            tick();
            s_fin = 1'b0;
            s_rd_valid = 1'b1;
            repeat (SBL - 1) tick();
            s_fin = 1'b1;
            tick();
            s_rd_valid = 1'b0;
            s_fin = 1'b0;
            tick();
            exp = ((b + 1) * SBL > 65535) ? 65535 : (b + 1) * SBL;
            if (b == 0 || b == 126 || b == 127 || b == 129)
                check("sat_error_cnt", 64'(s_error_cnt), 64'(exp));
        end
        check("sat_flags", 64'({s_error, s_pass_cnt}), 64'({1'b1, 16'd0}));
        sat_done = 1'b1;
    end
endmodule
